alu_stream_pipeline: RTL and testbench

//  Parametrised-depth ALU pipeline with valid/ready handshakes on both ends and per-transaction
//  op select. Stage 1 computes op1 <sel> op2. Stage 2 optionally subtracts op1 from that result.
//  The remaining stages are delay registers.

---
 rtl/alu_stream_pipeline.sv | 115 +++++++++++
 tb/tb_alu_stream_pipeline.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stream_pipeline.sv
// rtl/alu_stream_pipeline.sv - parametrised-depth ALU pipeline with valid/ready handshakes, flush, flags and occupancy
//
// Stage 0 registers op1 <sel> op2 together with op1 and post_sub.
// Stage 1 optionally subtracts op1 from the stage 0 result.
// Any further stages are plain delay registers. The last stage drives the outputs.
//
// Ports:
//   clk, rst                  clock and synchronous active-low reset
//   in_valid_i / in_ready_o   operand beat handshake (op1_i, op2_i, sel_i, post_sub_i)
//   flush_i                   discard every in-flight beat at the next edge
//   out_valid_o / out_ready_i result beat handshake (res_o, zero_o, neg_o)
//   occupancy_o               number of valid stages
module alu_stream_pipeline #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DWIDTH-1:0]          op1_i,
    input  logic [DWIDTH-1:0]          op2_i,
    input  logic [1:0]                 sel_i,
    input  logic                       post_sub_i,
    input  logic                       flush_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DWIDTH-1:0]          res_o,
    output logic                       zero_o,
    output logic                       neg_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int OW   = $clog2(DEPTH+1);
    localparam int LAST = DEPTH - 1;

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  adv;
    logic [DWIDTH-1:0] data_q [DEPTH];
    logic [DWIDTH-1:0] op1_q;
    logic              post_sub_q;
    logic [DWIDTH-1:0] alu_res;
    logic [DWIDTH-1:0] stage2_res;
    logic              accept;

    always_comb begin
        alu_res = op1_i | op2_i;
        case (sel_i)
            2'b00:   alu_res = op1_i + op2_i;
            2'b01:   alu_res = op1_i - op2_i;
            2'b10:   alu_res = op1_i & op2_i;
            default: alu_res = op1_i | op2_i;
        endcase
    end

    // Advance chain is resolved from the output backwards; a running local
    // keeps each stage's term free of any dependency on the adv vector itself.
    always_comb begin
        logic go;
        adv       = '0;
        go        = valid_q[LAST] && out_ready_i;
        adv[LAST] = go;
        for (int k = LAST - 1; k >= 0; k--) begin
            go     = valid_q[k] && (!valid_q[k+1] || go);
            adv[k] = go;
        end
    end

    assign in_ready_o = rst && !flush_i && (!valid_q[0] || adv[0]);
    assign accept     = in_valid_i && in_ready_o;
    assign stage2_res = post_sub_q ? (data_q[0] - op1_q) : data_q[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            op1_q      <= '0;
            post_sub_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // Data only moves with its stage, so empty stages never pick up junk.
            if (accept) begin
                data_q[0]  <= alu_res;
                op1_q      <= op1_i;
                post_sub_q <= post_sub_i;
            end
            if (adv[0]) begin
                data_q[1] <= stage2_res;
            end
            for (int k = 2; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end

            if (flush_i) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= accept || (valid_q[0] && !adv[0]);
                for (int k = 1; k < DEPTH; k++) begin
                    valid_q[k] <= adv[k-1] || (valid_q[k] && !adv[k]);
                end
            end
        end
    end

    // Flags are gated by the output valid so that they read 0 after reset/flush.
    assign out_valid_o = valid_q[LAST];
    assign res_o       = data_q[LAST];
    assign zero_o      = valid_q[LAST] && (data_q[LAST] == '0);
    assign neg_o       = valid_q[LAST] && data_q[LAST][DWIDTH-1];
    assign occupancy_o = OW'($countones(valid_q));

endmodule

// File: tb/tb_alu_stream_pipeline.sv
// tb/tb_alu_stream_pipeline.sv - self-checking bench for alu_stream_pipeline
module tb_alu_stream_pipeline;

    localparam int DW = 8;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [1:0]    sel;
    logic          post_sub;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] res;
    logic          zero;
    logic          neg;
    logic [1:0]    occupancy;

    alu_stream_pipeline #(.DWIDTH(DW), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op1_i       (op1),
        .op2_i       (op2),
        .sel_i       (sel),
        .post_sub_i  (post_sub),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .zero_o      (zero),
        .neg_o       (neg),
        .occupancy_o (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        int            t;
    } beat_t;

    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [1:0]    sel;
        logic          ps;
        logic [DW-1:0] exp_res;
        logic          exp_zero;
        logic          exp_neg;
    } vec_t;

    beat_t q[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    int    dut_accepts = 0;

    function automatic logic [DW-1:0] ref_res(int a, int b, int s, bit ps);
        int r;
        case (s)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        if (ps) r = r - a;
        return r[DW-1:0];
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic tick();
        bit exp_valid;
        bit exp_ready;
        bit acc;
        bit outh;
        beat_t b;
        @(negedge clk);
        exp_valid = 1'b0;
        exp_ready = 1'b0;
        if (rst) begin
            exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= D - 1);
            exp_ready = !flush && ((q.size() < D) || out_ready);
            chk("out_valid", int'(out_valid), int'(exp_valid));
            if (exp_valid) begin
                chk("res", int'(res), int'(q[0].res));
                chk("zero", int'(zero), int'(q[0].res == 0));
                chk("neg", int'(neg), int'(q[0].res[DW-1]));
            end
            chk("occupancy", int'(occupancy), q.size());
        end
        chk("in_ready", int'(in_ready), int'(exp_ready));
        if (in_valid && in_ready) dut_accepts++;
        acc  = in_valid && exp_ready;
        outh = exp_valid && out_ready;
        b.res = ref_res(int'(op1), int'(op2), int'(sel), post_sub);
        @(posedge clk);
        cyc++;
        b.t = cyc;
        if (!rst) begin
            q.delete();
        end else begin
            if (outh) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) q.push_back(b);
        end
        #1;
    endtask

    task automatic rand_ops();
        op1      = DW'($urandom);
        op2      = DW'($urandom);
        sel      = 2'($urandom);
        post_sub = 1'($urandom);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'd5,   8'd3,   2'b00, 1'b1, 8'd3,   1'b0, 1'b0};
        vecs[1] = '{8'd200, 8'd100, 2'b00, 1'b0, 8'd44,  1'b0, 1'b0};
        vecs[2] = '{8'd3,   8'd5,   2'b01, 1'b0, 8'd254, 1'b0, 1'b1};
        vecs[3] = '{8'd6,   8'd9,   2'b10, 1'b0, 8'd0,   1'b1, 1'b0};
        vecs[4] = '{8'hF0,  8'h0F,  2'b11, 1'b0, 8'd255, 1'b0, 1'b1};
        vecs[5] = '{8'd10,  8'd10,  2'b01, 1'b1, 8'd246, 1'b0, 1'b1};
        vecs[6] = '{8'd7,   8'd7,   2'b10, 1'b1, 8'd0,   1'b1, 1'b0};
        vecs[7] = '{8'd128, 8'd0,   2'b11, 1'b0, 8'd128, 1'b0, 1'b1};

        rst = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0; sel = '0;
        post_sub = 1'b0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_res", int'(res), 0);
        chk("rst_zero", int'(zero), 0);
        chk("rst_neg", int'(neg), 0);
        chk("rst_occupancy", int'(occupancy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        tick();

        // Table vectors: single beat, unstalled latency D
        foreach (vecs[i]) begin
            op1 = vecs[i].op1; op2 = vecs[i].op2;
            sel = vecs[i].sel; post_sub = vecs[i].ps;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < D - 1; k++) tick();
            chk("vec_valid", int'(out_valid), 1);
            chk("vec_res", int'(res), int'(vecs[i].exp_res));
            chk("vec_zero", int'(zero), int'(vecs[i].exp_zero));
            chk("vec_neg", int'(neg), int'(vecs[i].exp_neg));
            tick();
        end

        // Backpressure: 5 offered beats, only D accepted
        out_ready = 1'b0;
        dut_accepts = 0;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("stall_accepts", dut_accepts, D);
        chk("stall_occupancy", int'(occupancy), D);
        chk("stall_in_ready", int'(in_ready), 0);
        out_ready = 1'b1;
        for (int k = 0; k < D + 2; k++) tick();
        chk("drain_occupancy", int'(occupancy), 0);

        // Flush of a full pipe with a beat offered in the flush cycle
        out_ready = 1'b0;
        for (int k = 0; k < D; k++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        flush = 1'b1;
        rand_ops();
        dut_accepts = 0;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_accepts", dut_accepts, 0);
        chk("flush_out_valid", int'(out_valid), 0);
        chk("flush_occupancy", int'(occupancy), 0);
        out_ready = 1'b1;
        tick();

        // Continuous stream, 1000 random beats
        out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        chk("stream_occupancy", int'(occupancy), D);
        in_valid = 1'b0;
        for (int k = 0; k < D + 1; k++) tick();

        // Mixed random valid/ready/flush traffic
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < D + 1; k++) tick();

        // Reset mid-stream with two beats in flight
        for (int k = 0; k < 2; k++) begin
            rand_ops();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_res", int'(res), 0);
        chk("mid_rst_occupancy", int'(occupancy), 0);
        rst = 1'b1;
        op1 = 8'd5; op2 = 8'd3; sel = 2'b00; post_sub = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < D - 1; k++) tick();
        chk("post_rst_valid", int'(out_valid), 1);
        chk("post_rst_res", int'(res), 3);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
